// File: rtl/track_aim_if.sv
// Step request channel between the aiming controller and the stepper driver.
// One request outstanding at a time; axis/dir held while step_req is high.
interface track_aim_if;
    logic step_req;
    logic step_axis;
    logic step_dir;
    logic step_ack;

    modport master (
        output step_req,
        output step_axis,
        output step_dir,
        input  step_ack
    );

    modport slave (
        input  step_req,
        input  step_axis,
        input  step_dir,
        output step_ack
    );
endinterface

// File: rtl/track_aim_ctrl.sv
// Pan/tilt aiming controller: turns predicted target position into step
// bursts, tracks signed step positions and runs IDLE/TRACK/WAIT/SEARCH.
module track_aim_ctrl #(
    parameter int UPDATE_PERIOD = 2_000_000,
    parameter int CENTER_X      = 319,
    parameter int CENTER_Y      = 239,
    parameter int DEADBAND      = 4,
    parameter int ERR_SHIFT     = 3,
    parameter int MAX_STEPS     = 8,
    parameter int LOST_TICKS    = 10,
    parameter int PAN_LIMIT     = 200,
    parameter int TILT_LIMIT    = 100
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic [15:0]        x_target,
    input  logic [15:0]        y_target,
    input  logic               target_valid,
    track_aim_if.master        step,
    output logic signed [15:0] pan_pos,
    output logic signed [15:0] tilt_pos,
    output logic               locked,
    output logic [1:0]         state_out
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_TRACK  = 2'b01,
        S_WAIT   = 2'b10,
        S_SEARCH = 2'b11
    } state_t;

    localparam logic signed [16:0] CX   = 17'(CENTER_X);
    localparam logic signed [16:0] CY   = 17'(CENTER_Y);
    localparam logic [16:0]        DB   = 17'(DEADBAND);
    localparam logic [16:0]        MS   = 17'(MAX_STEPS);
    localparam logic [7:0]         LT   = 8'(LOST_TICKS);
    localparam logic signed [15:0] PL   = 16'(PAN_LIMIT);
    localparam logic signed [15:0] TL   = 16'(TILT_LIMIT);
    localparam logic [31:0]        TEND = 32'(UPDATE_PERIOD - 1);

    state_t      state;
    logic [31:0] tcnt;
    logic        tick;
    logic [7:0]  pan_n;
    logic [7:0]  tilt_n;
    logic        pan_d;
    logic        tilt_d;
    logic        sweep_dir;
    logic [7:0]  lost_cnt;
    logic        busy;

    logic signed [16:0] ex;
    logic signed [16:0] ey;
    logic [16:0] ax;
    logic [16:0] ay;
    logic [7:0]  nx;
    logic [7:0]  ny;
    logic        pan_ok;
    logic        tilt_ok;

    // Step count for one axis: deadband, shift, clamp to [1, MAX_STEPS].
    function automatic logic [7:0] steps_for(input logic [16:0] a);
        logic [16:0] s;
        s = a >> ERR_SHIFT;
        if (a <= DB)
            return 8'd0;
        else if (s > MS)
            return MS[7:0];
        else if (s == 17'd0)
            return 8'd1;
        else
            return s[7:0];
    endfunction

    assign ex = signed'({1'b0, x_target}) - CX;
    assign ey = signed'({1'b0, y_target}) - CY;
    assign ax = ex[16] ? 17'(-ex) : 17'(ex);
    assign ay = ey[16] ? 17'(-ey) : 17'(ey);
    assign nx = steps_for(ax);
    assign ny = steps_for(ay);

    assign pan_ok  = pan_d  ? (pan_pos  < PL) : (pan_pos  > -PL);
    assign tilt_ok = tilt_d ? (tilt_pos < TL) : (tilt_pos > -TL);

    assign busy      = step.step_req | (pan_n != 8'd0) | (tilt_n != 8'd0);
    assign tick      = (tcnt == TEND);
    assign state_out = state;

    // Free-running update tick counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            tcnt <= '0;
        else if (tick)
            tcnt <= '0;
        else
            tcnt <= tcnt + 32'd1;
    end

    // Handshake, burst sequencing, position tracking and mode FSM.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            pan_n          <= '0;
            tilt_n         <= '0;
            pan_d          <= 1'b0;
            tilt_d         <= 1'b0;
            sweep_dir      <= 1'b1;
            lost_cnt       <= '0;
            locked         <= 1'b0;
            pan_pos        <= '0;
            tilt_pos       <= '0;
            step.step_req  <= 1'b0;
            step.step_axis <= 1'b0;
            step.step_dir  <= 1'b0;
        end else begin
            if (step.step_req && step.step_ack) begin
                step.step_req <= 1'b0;
                if (step.step_axis)
                    tilt_pos <= step.step_dir ? tilt_pos + 16'sd1
                                              : tilt_pos - 16'sd1;
                else
                    pan_pos <= step.step_dir ? pan_pos + 16'sd1
                                             : pan_pos - 16'sd1;
            end

            if (!enable) begin
                // Abandon queued steps; leave only once the open step is done.
                pan_n  <= '0;
                tilt_n <= '0;
                if (!step.step_req) begin
                    state  <= S_IDLE;
                    locked <= 1'b0;
                end
            end else if (!step.step_req && (pan_n != 8'd0)) begin
                pan_n <= pan_n - 8'd1;
                if (pan_ok) begin
                    step.step_req  <= 1'b1;
                    step.step_axis <= 1'b0;
                    step.step_dir  <= pan_d;
                end
            end else if (!step.step_req && (tilt_n != 8'd0)) begin
                tilt_n <= tilt_n - 8'd1;
                if (tilt_ok) begin
                    step.step_req  <= 1'b1;
                    step.step_axis <= 1'b1;
                    step.step_dir  <= tilt_d;
                end
            end else if (tick && !busy) begin
                if (target_valid) begin
                    state    <= S_TRACK;
                    pan_n    <= nx;
                    pan_d    <= ~ex[16];
                    tilt_n   <= ny;
                    tilt_d   <= ~ey[16];
                    locked   <= (nx == 8'd0) && (ny == 8'd0);
                    lost_cnt <= '0;
                end else begin
                    unique case (state)
                        S_IDLE, S_TRACK: begin
                            state    <= S_WAIT;
                            lost_cnt <= 8'd1;
                            locked   <= 1'b0;
                        end
                        S_WAIT: begin
                            lost_cnt <= lost_cnt + 8'd1;
                            if (lost_cnt + 8'd1 == LT)
                                state <= S_SEARCH;
                        end
                        S_SEARCH: begin
                            if (tilt_pos != 16'sd0) begin
                                tilt_n <= 8'd1;
                                tilt_d <= tilt_pos[15];
                            end else if (sweep_dir && pan_pos >= PL) begin
                                sweep_dir <= 1'b0;
                                pan_n     <= 8'd1;
                                pan_d     <= 1'b0;
                            end else if (!sweep_dir && pan_pos <= -PL) begin
                                sweep_dir <= 1'b1;
                                pan_n     <= 8'd1;
                                pan_d     <= 1'b1;
                            end else begin
                                pan_n <= 8'd1;
                                pan_d <= sweep_dir;
                            end
                        end
                        default: state <= S_IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_track_aim_ctrl.sv
// Directed bench for track_aim_ctrl with a stepper-driver ack model.
// Short update period and small pan limit keep scenarios quick.
module tb_track_aim_ctrl;

    logic               clk;
    logic               reset_n;
    logic               enable;
    logic [15:0]        x_target;
    logic [15:0]        y_target;
    logic               target_valid;
    logic signed [15:0] pan_pos;
    logic signed [15:0] tilt_pos;
    logic               locked;
    logic [1:0]         state_out;

    track_aim_if sif ();

    track_aim_ctrl #(
        .UPDATE_PERIOD(100),
        .LOST_TICKS   (3),
        .PAN_LIMIT    (5)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .x_target    (x_target),
        .y_target    (y_target),
        .target_valid(target_valid),
        .step        (sif),
        .pan_pos     (pan_pos),
        .tilt_pos    (tilt_pos),
        .locked      (locked),
        .state_out   (state_out)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int ack_delay = 3;
    int acnt = 0;
    logic ack_m = 1'b0;
    logic ack_stray = 1'b0;
    int tcnt = 0;
    int cnt_pp = 0, cnt_pn = 0, cnt_tp = 0, cnt_tn = 0;
    int rises = 0, stab_err = 0;
    logic req_q = 1'b0, axis_q = 1'b0, dir_q = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign sif.step_ack = ack_m | ack_stray;

    // Driver model: ack ack_delay cycles after a request rises.
    always @(posedge clk) begin
        if (!sif.step_req) begin
            acnt  <= 0;
            ack_m <= 1'b0;
        end else if (ack_m) begin
            ack_m <= 1'b0;
        end else if (acnt == ack_delay - 1) begin
            ack_m <= 1'b1;
        end else begin
            acnt <= acnt + 1;
        end
    end

    // Mirror of the update tick timing.
    always @(posedge clk) begin
        if (!reset_n)
            tcnt <= 0;
        else
            tcnt <= (tcnt == 99) ? 0 : tcnt + 1;
    end

    // Handshake monitor: completions per axis/dir, rises, stability.
    always @(posedge clk) begin
        if (reset_n) begin
            if (sif.step_req && sif.step_ack) begin
                if (!sif.step_axis && sif.step_dir)  cnt_pp <= cnt_pp + 1;
                if (!sif.step_axis && !sif.step_dir) cnt_pn <= cnt_pn + 1;
                if (sif.step_axis && sif.step_dir)   cnt_tp <= cnt_tp + 1;
                if (sif.step_axis && !sif.step_dir)  cnt_tn <= cnt_tn + 1;
            end
            if (sif.step_req && !req_q)
                rises <= rises + 1;
            if (sif.step_req && req_q &&
                (sif.step_axis != axis_q || sif.step_dir != dir_q))
                stab_err <= stab_err + 1;
        end
        req_q  <= sif.step_req;
        axis_q <= sif.step_axis;
        dir_q  <= sif.step_dir;
    end

    task automatic do_reset();
        reset_n      = 1'b0;
        enable       = 1'b0;
        target_valid = 1'b0;
        x_target     = 16'd319;
        y_target     = 16'd239;
        ack_stray    = 1'b0;
        ack_delay    = 3;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) begin
            forever begin
                @(posedge clk);
                if (tcnt == 99) break;
            end
        end
        #1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_req(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (sif.step_req) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        bit seen;
        do_reset();
        #1;
        n_checks++;
        if (sif.step_req !== 1'b0 || pan_pos !== 16'sd0 || tilt_pos !== 16'sd0 ||
            locked !== 1'b0 || state_out !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_state: req=%b pan=%0d tilt=%0d lock=%b st=%b want all 0",
                     sif.step_req, pan_pos, tilt_pos, locked, state_out);
        end
        enable = 1'b1; target_valid = 1'b1;
        x_target = 16'd351; y_target = 16'd239;
        wait_ticks(1);
        wait_req(seen);
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL reset_req_timeout: no step_req seen, want 1");
        end
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (sif.step_req !== 1'b0 || pan_pos !== 16'sd0 || state_out !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_mid_hs: req=%b pan=%0d st=%b want 0 0 00",
                     sif.step_req, pan_pos, state_out);
        end
        wait_cycles(5);
        n_checks++;
        if (pan_pos !== 16'sd0) begin
            n_fail++;
            $display("FAIL reset_no_count: pan=%0d want 0", pan_pos);
        end
    endtask

    task automatic test_pan_only();
        int p0, t0;
        do_reset();
        enable = 1'b1; target_valid = 1'b1;
        x_target = 16'd351; y_target = 16'd239;
        p0 = cnt_pp; t0 = cnt_tp + cnt_tn;
        wait_ticks(1);
        n_checks++;
        if (state_out !== 2'b01) begin
            n_fail++;
            $display("FAIL pan_state: got %b want 01", state_out);
        end
        wait_cycles(90);
        n_checks++;
        if (pan_pos !== 16'sd4 || cnt_pp - p0 != 4 || cnt_tp + cnt_tn - t0 != 0) begin
            n_fail++;
            $display("FAIL pan_steps: pan=%0d pos_steps=%0d tilt_steps=%0d want 4 4 0",
                     pan_pos, cnt_pp - p0, cnt_tp + cnt_tn - t0);
        end
        n_checks++;
        if (locked !== 1'b0) begin
            n_fail++;
            $display("FAIL pan_locked: got %b want 0", locked);
        end
    endtask

    task automatic test_limits();
        int pn0, tp0;
        do_reset();
        enable = 1'b1; target_valid = 1'b1;
        x_target = 16'd0; y_target = 16'd479;
        pn0 = cnt_pn; tp0 = cnt_tp;
        wait_ticks(1);
        wait_cycles(90);
        n_checks++;
        if (pan_pos !== -16'sd5 || cnt_pn - pn0 != 5) begin
            n_fail++;
            $display("FAIL limit_pan: pan=%0d neg_steps=%0d want -5 5",
                     pan_pos, cnt_pn - pn0);
        end
        n_checks++;
        if (tilt_pos !== 16'sd8 || cnt_tp - tp0 != 8) begin
            n_fail++;
            $display("FAIL limit_tilt: tilt=%0d pos_steps=%0d want 8 8",
                     tilt_pos, cnt_tp - tp0);
        end
    endtask

    task automatic test_deadband();
        int r0;
        do_reset();
        enable = 1'b1; target_valid = 1'b1;
        x_target = 16'd322; y_target = 16'd236;
        r0 = rises;
        wait_ticks(1);
        n_checks++;
        if (locked !== 1'b1 || state_out !== 2'b01) begin
            n_fail++;
            $display("FAIL deadband_lock: lock=%b st=%b want 1 01", locked, state_out);
        end
        ack_stray = 1'b1;
        wait_cycles(4);
        ack_stray = 1'b0;
        wait_cycles(40);
        n_checks++;
        if (rises != r0 || pan_pos !== 16'sd0 || tilt_pos !== 16'sd0) begin
            n_fail++;
            $display("FAIL deadband_nostep: reqs=%0d pan=%0d tilt=%0d want 0 0 0",
                     rises - r0, pan_pos, tilt_pos);
        end
    endtask

    task automatic test_search();
        do_reset();
        enable = 1'b1; target_valid = 1'b1;
        x_target = 16'd400; y_target = 16'd263;
        wait_ticks(1);
        wait_cycles(90);
        n_checks++;
        if (pan_pos !== 16'sd5 || tilt_pos !== 16'sd3) begin
            n_fail++;
            $display("FAIL search_setup: pan=%0d tilt=%0d want 5 3", pan_pos, tilt_pos);
        end
        target_valid = 1'b0;
        wait_ticks(1);
        n_checks++;
        if (state_out !== 2'b10 || locked !== 1'b0) begin
            n_fail++;
            $display("FAIL search_wait: st=%b lock=%b want 10 0", state_out, locked);
        end
        wait_ticks(1);
        n_checks++;
        if (state_out !== 2'b10) begin
            n_fail++;
            $display("FAIL search_wait2: st=%b want 10", state_out);
        end
        wait_ticks(1);
        n_checks++;
        if (state_out !== 2'b11) begin
            n_fail++;
            $display("FAIL search_enter: st=%b want 11", state_out);
        end
        wait_ticks(3);
        wait_cycles(30);
        n_checks++;
        if (tilt_pos !== 16'sd0 || pan_pos !== 16'sd5) begin
            n_fail++;
            $display("FAIL search_tilt_home: tilt=%0d pan=%0d want 0 5", tilt_pos, pan_pos);
        end
        wait_ticks(1);
        wait_cycles(30);
        n_checks++;
        if (pan_pos !== 16'sd4) begin
            n_fail++;
            $display("FAIL search_flip_hi: pan=%0d want 4", pan_pos);
        end
        wait_ticks(9);
        wait_cycles(30);
        n_checks++;
        if (pan_pos !== -16'sd5) begin
            n_fail++;
            $display("FAIL search_sweep_lo: pan=%0d want -5", pan_pos);
        end
        wait_ticks(10);
        wait_cycles(30);
        n_checks++;
        if (pan_pos !== 16'sd5 || state_out !== 2'b11) begin
            n_fail++;
            $display("FAIL search_sweep_hi: pan=%0d st=%b want 5 11", pan_pos, state_out);
        end
        target_valid = 1'b1;
        x_target = 16'd319; y_target = 16'd239;
        wait_ticks(1);
        n_checks++;
        if (state_out !== 2'b01 || locked !== 1'b1) begin
            n_fail++;
            $display("FAIL search_reacquire: st=%b lock=%b want 01 1", state_out, locked);
        end
    endtask

    task automatic test_back_to_back();
        int t0;
        do_reset();
        ack_delay = 15;
        enable = 1'b1; target_valid = 1'b1;
        x_target = 16'd319; y_target = 16'd479;
        t0 = cnt_tp;
        wait_ticks(1);
        y_target = 16'd279;
        wait_ticks(1);
        n_checks++;
        if (cnt_tp - t0 >= 8 || state_out !== 2'b01) begin
            n_fail++;
            $display("FAIL b2b_midburst: steps=%0d st=%b want <8 01",
                     cnt_tp - t0, state_out);
        end
        wait_cycles(60);
        n_checks++;
        if (tilt_pos !== 16'sd8 || cnt_tp - t0 != 8) begin
            n_fail++;
            $display("FAIL b2b_dropped: tilt=%0d steps=%0d want 8 8",
                     tilt_pos, cnt_tp - t0);
        end
        wait_ticks(1);
        wait_cycles(95);
        n_checks++;
        if (tilt_pos !== 16'sd13) begin
            n_fail++;
            $display("FAIL b2b_next_tick: tilt=%0d want 13", tilt_pos);
        end
        ack_delay = 3;
    endtask

    task automatic test_disable();
        bit seen;
        int c0, r0;
        do_reset();
        enable = 1'b1; target_valid = 1'b1;
        x_target = 16'd0; y_target = 16'd479;
        wait_ticks(1);
        wait_req(seen);
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL disable_req_timeout: no step_req seen, want 1");
        end
        c0 = cnt_pn;
        enable = 1'b0;
        wait_cycles(30);
        n_checks++;
        if (cnt_pn - c0 != 1 || pan_pos !== -16'sd1 || state_out !== 2'b00 ||
            sif.step_req !== 1'b0) begin
            n_fail++;
            $display("FAIL disable_abandon: steps=%0d pan=%0d st=%b req=%b want 1 -1 00 0",
                     cnt_pn - c0, pan_pos, state_out, sif.step_req);
        end
        r0 = rises;
        wait_ticks(1);
        wait_cycles(20);
        n_checks++;
        if (rises != r0 || state_out !== 2'b00) begin
            n_fail++;
            $display("FAIL disable_idle: reqs=%0d st=%b want 0 00", rises - r0, state_out);
        end
    endtask

    initial begin
        test_reset();
        test_pan_only();
        test_limits();
        test_deadband();
        test_search();
        test_back_to_back();
        test_disable();
        n_checks++;
        if (stab_err != 0) begin
            n_fail++;
            $display("FAIL req_stability: %0d changes of axis/dir under req, want 0", stab_err);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
